// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: instruction-memory request/grant/response, core redirect and
// the instruction valid/ready channel toward the fetch stage.
interface fetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    // master: the fetch buffer itself
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    // slave: memory plus core environment
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: sequential fetch with credit-limited issue, PC-tagged FIFO,
// redirect flush with stale-response discard. Optional FETCH_BYPASS_EN forwards a response
// straight to the fetch stage when the FIFO is empty.
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_buffer_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, resp_pc_q;
    logic [CW-1:0] outstanding_q, discard_q, count_q;
    logic [PW-1:0] head_q, tail_q;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];

    logic          head_valid, accept, drop, bypass, push, pop;
    logic [CW:0]   in_use;
    logic [CW-1:0] out_after_rsp;

    assign head_valid    = (count_q != '0);
    assign in_use        = {1'b0, count_q} + {1'b0, outstanding_q};
    // Queued plus in-flight words never exceed DEPTH, so a returning word always fits.
    assign bus.imem_req  = !reset && !bus.redirect_valid && (in_use < DEPTH_W);
    assign bus.imem_addr = fetch_pc_q;
    assign accept        = bus.imem_req && bus.imem_gnt;
    assign drop          = bus.redirect_valid || (discard_q != '0);
    assign out_after_rsp = outstanding_q - CW'(bus.imem_rvalid);

`ifdef FETCH_BYPASS_EN
    assign bypass = !head_valid && !drop && bus.imem_rvalid;
`else
    assign bypass = 1'b0;
`endif

    assign bus.inst_valid = (head_valid || bypass) && !bus.redirect_valid;
    assign pop            = head_valid && !bus.redirect_valid && bus.inst_ready;
    assign push           = bus.imem_rvalid && !drop && !(bypass && bus.inst_ready);

    always_comb begin
        bus.inst    = '0;
        bus.inst_pc = '0;
        if (head_valid && !bus.redirect_valid) begin
            bus.inst    = fifo_word_q[head_q];
            bus.inst_pc = fifo_pc_q[head_q];
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            bus.inst    = bus.imem_rdata;
            bus.inst_pc = resp_pc_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_word_q[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_q    <= bus.redirect_pc;
            resp_pc_q     <= bus.redirect_pc;
            outstanding_q <= out_after_rsp;
            discard_q     <= out_after_rsp;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            if (accept) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            outstanding_q <= out_after_rsp + CW'(accept);
            if (bus.imem_rvalid) begin
                if (discard_q != '0) begin
                    discard_q <= discard_q - CW'(1);
                end else begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
            end
            if (push) begin
                fifo_pc_q[tail_q]   <= resp_pc_q;
                fifo_word_q[tail_q] <= bus.imem_rdata;
                tail_q              <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    a_rvalid_has_credit: assert property (
        @(posedge clk) disable iff (reset) bus.imem_rvalid |-> (outstanding_q != '0)
    );
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a fixed-latency in-order memory model (data = address).
module tb_fetch_buffer;
    localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_buffer_if bus ();

    fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t pend[$];
    int    lat = 1;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: capture an accepted request, then drive this cycle's memory response.
    task automatic step();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = bus.imem_req && bus.imem_gnt;
        a   = bus.imem_addr;
        @(posedge clk);
        cyc++;
        if (acc && !reset) pend.push_back('{due: cyc + lat - 1, data: a});
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hdead_beef;
        end
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_rvalid    = 1'b0;
        pend.delete();
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_inst(input int budget, output logic found,
                             output logic [31:0] pc, output logic [31:0] w);
        found = 1'b0;
        pc    = '0;
        w     = '0;
        for (int i = 0; i < budget && !found; i++) begin
            #1;
            if (bus.inst_valid) begin
                found = 1'b1;
                pc    = bus.inst_pc;
                w     = bus.inst;
            end else begin
                step();
            end
        end
    endtask

    logic        found;
    logic [31:0] pc, w;
    int          n_acc, popped;
    logic        seen;

    initial begin
        bus.imem_gnt       = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;

        // Reset values, then streaming at one instruction per cycle.
        lat = 1;
        pend.delete();
        step();
        step();
        #1;
        check("rst_req", 32'(bus.imem_req), 0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", 32'(bus.inst_valid), 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        reset = 1'b0;
        cyc   = 0;
        #1;
        check("a_first_req", 32'(bus.imem_req), 1);
        check("a_first_addr", bus.imem_addr, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            step();
            #1;
            if (c < FIRST) begin
                check("a_not_yet_valid", 32'(bus.inst_valid), 0);
            end else begin
                check("a_valid", 32'(bus.inst_valid), 1);
                check("a_pc", bus.inst_pc, 32'((c - FIRST) * 4));
                check("a_inst", bus.inst, 32'((c - FIRST) * 4));
            end
        end

        // Credit limit with a stalled consumer, then in-order drain.
        bus.inst_ready = 1'b0;
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.imem_req && bus.imem_gnt) begin
                if (n_acc < 4) check("b_req_addr", bus.imem_addr, 32'(n_acc * 4));
                n_acc++;
            end
            step();
        end
        check("b_accepted", 32'(n_acc), 4);
        #1;
        check("b_req_stalled", 32'(bus.imem_req), 0);
        check("b_head_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        popped = 0;
        seen   = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.inst_valid) begin
                if (popped < 6) begin
                    check("b_drain_pc", bus.inst_pc, 32'(popped * 4));
                    check("b_drain_inst", bus.inst, 32'(popped * 4));
                end
                popped++;
            end
            if (bus.imem_req && !seen) begin
                check("b_resume_addr", bus.imem_addr, 32'h10);
                seen = 1'b1;
            end
            step();
        end
        check("b_resume_seen", 32'(seen), 1);
        check("b_drained_enough", 32'(popped >= 6), 1);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        check("c_no_req_on_redirect", 32'(bus.imem_req), 0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("c_req_after", 32'(bus.imem_req), 1);
        check("c_addr_after", bus.imem_addr, 32'h100);
        wait_inst(12, found, pc, w);
        check("c_found", 32'(found), 1);
        check("c_first_pc", pc, 32'h100);
        check("c_first_inst", w, 32'h100);

        // Redirect colliding with a response and a pop.
        lat = 3;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        #1;
        check("d_pre_valid", 32'(bus.inst_valid), 1);
        check("d_pre_pc", bus.inst_pc, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        check("d_valid_masked", 32'(bus.inst_valid), 0);
        check("d_inst_zero", bus.inst, 0);
        check("d_req_masked", 32'(bus.imem_req), 0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("d_fifo_empty", 32'(bus.inst_valid), 0);
        check("d_discard", 32'(dut.discard_q), 2);
        check("d_new_addr", bus.imem_addr, 32'h200);
        wait_inst(12, found, pc, w);
        check("d_found", 32'(found), 1);
        check("d_first_pc", pc, 32'h200);

        // Grant withheld: request and address hold, no credit consumed.
        lat = 8;
        do_reset();
        step();
        step();
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("e_req_held", 32'(bus.imem_req), 1);
            check("e_addr_held", bus.imem_addr, 32'h8);
            check("e_outstanding", 32'(dut.outstanding_q), 2);
            step();
        end
        bus.imem_gnt = 1'b1;
        step();
        #1;
        check("e_addr_advance", bus.imem_addr, 32'hc);

        // Asynchronous reset with three entries queued.
        lat = 1;
        bus.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        #1;
        check("f_pre_valid", 32'(bus.inst_valid), 1);
        check("f_pre_count", 32'(dut.count_q), 3);
        reset           = 1'b1;
        bus.imem_rvalid = 1'b0;
        pend.delete();
        #1;
        check("f_async_valid", 32'(bus.inst_valid), 0);
        check("f_async_req", 32'(bus.imem_req), 0);
        step();
        step();
        reset          = 1'b0;
        cyc            = 0;
        bus.inst_ready = 1'b1;
        #1;
        check("f_rel_addr", bus.imem_addr, 32'h0);
        check("f_rel_req", 32'(bus.imem_req), 1);
        check("f_rel_valid", 32'(bus.inst_valid), 0);
`ifndef FETCH_BYPASS_EN
        step();
        #1;
        check("f_rel_valid_c1", 32'(bus.inst_valid), 0);
`endif
        wait_inst(8, found, pc, w);
        check("f_found", 32'(found), 1);
        check("f_first_pc", pc, 32'h0);

        // Back-to-back redirects, last one wraps the PC past 2^32.
        lat = 1;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        check("g_req_masked0", 32'(bus.imem_req), 0);
        step();
        bus.redirect_pc = 32'hffff_fffc;
        #1;
        check("g_req_masked1", 32'(bus.imem_req), 0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("g_addr", bus.imem_addr, 32'hffff_fffc);
        wait_inst(8, found, pc, w);
        check("g_found", 32'(found), 1);
        check("g_first_pc", pc, 32'hffff_fffc);
        step();
        #1;
        check("g_wrap_valid", 32'(bus.inst_valid), 1);
        check("g_wrap_pc", bus.inst_pc, 32'h0);
        check("g_wrap_inst", bus.inst, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer between the core's fetch stage and an instruction memory with request/grant handshake and variable, in-order read latency. Issues sequential word fetches from a local fetch PC, queues returned instructions with their PCs in a DEPTH-entry FIFO, and presents them to fetch with a valid/ready handshake. A redirect from the core (branch/jump target) flushes the queue and discards stale in-flight responses.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding-plus-queued words; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (= fetch PC)
- imem_gnt  in  1  request accepted this cycle when imem_req && imem_gnt
- imem_rvalid  in  1  one response word returned this cycle (in request order)
- imem_rdata  in  32  response instruction word
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address, word aligned
- inst_valid  out  1  head instruction available
- inst  out  32  head instruction word
- inst_pc  out  32  PC of head instruction
- inst_ready  in  1  fetch stage consumes head when inst_valid && inst_ready

## Operation
- State: fetch_pc (32), resp_pc (32), outstanding and discard counters ($clog2(DEPTH+1) bits), FIFO of {pc, word} with head/tail pointers and count.
- Issue: imem_req = !redirect_valid && (count + outstanding < DEPTH). imem_addr = fetch_pc. On accept: fetch_pc += 4, outstanding += 1. imem_addr must hold while imem_req && !imem_gnt.
- Response: on imem_rvalid, outstanding -= 1. If discard > 0: discard -= 1, word dropped. Else push {resp_pc, imem_rdata}, resp_pc += 4. Credit rule guarantees the FIFO never overflows; imem_rvalid with outstanding == 0 is illegal (assertion).
- Pop: inst_valid = (count != 0) && !redirect_valid; on inst_valid && inst_ready pop head.
- Redirect (highest priority): FIFO cleared; fetch_pc ← redirect_pc; resp_pc ← redirect_pc; no request issued that cycle; outstanding_next = outstanding − imem_rvalid; discard ← outstanding_next (every in-flight word is stale); any rvalid word that cycle is dropped.
- Simultaneous push and pop in a non-redirect cycle: count unchanged, both take effect.
- PCs wrap modulo 2^32.
- inst and inst_pc read 0 whenever inst_valid = 0 (except bypass case below).

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0; fetch_pc = resp_pc = RESET_PC; counters 0. Reset asserted mid-operation drops all queued and in-flight words; responses arriving after reset release for pre-reset requests are an environment error.
- First cycle after reset release: imem_req = 1, imem_addr = RESET_PC.
- Response-to-inst_valid latency: 1 cycle (registered FIFO) without bypass.
- Throughput: 1 instruction/cycle with single-cycle memory, imem_gnt = 1, inst_ready = 1, DEPTH ≥ 2.
- Redirect-to-first-new-request: request at redirect_pc issued the cycle after redirect_valid.
- redirect_valid is a single-cycle pulse per target; back-to-back pulses are legal, each restarting at its own redirect_pc.

## Configuration
- FETCH_BYPASS_EN defined: when FIFO is empty, discard == 0, no redirect, and imem_rvalid = 1, the response is driven combinationally onto inst/inst_pc with inst_valid = 1; if inst_ready = 1 it is consumed and not pushed, otherwise pushed. Response-to-inst_valid latency 0.
- Not defined: all responses pass through the FIFO; latency 1; no combinational path from imem_* to inst_*.

## Test plan
- Reset release, imem_gnt = 1, 1-cycle memory returning data = address, inst_ready = 1 → inst_pc/inst = 0x0, 0x4, 0x8… on consecutive cycles; first inst_valid at cycle 2 after release (cycle 1 with FETCH_BYPASS_EN).
- DEPTH = 4, inst_ready = 0 → exactly 4 requests accepted (0x0–0xC), then imem_req = 0; raise inst_ready → drains 0x0, 0x4, 0x8, 0xC in order, requests resume at 0x10.
- 3-cycle memory, 2 requests in flight, redirect_valid with redirect_pc = 0x100 → both stale words dropped, no request in redirect cycle, next request 0x100, first inst_pc = 0x100.
- Redirect in same cycle as imem_rvalid and inst_valid && inst_ready → inst_valid = 0 that cycle, word dropped, discard = outstanding − 1, FIFO empty next cycle.
- imem_gnt held 0 for 5 cycles → imem_req = 1, imem_addr stable at same value for all 5 cycles, outstanding unchanged.
- Assert reset asynchronously mid-stream with 3 entries queued → inst_valid and imem_req drop immediately (before next edge); after release imem_addr = RESET_PC, inst_valid = 0 until first new response.
